// File: rtl/store_queue_param_pkg.sv
// Shared types and sizing helpers for the parametrised store queue.
package store_queue_param_pkg;

  localparam int unsigned LOG2_MAX_IDS  = 3;
  localparam int unsigned FLEN_INTERNAL = 34;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned BE_W          = 4;
  localparam int unsigned FN3_W         = 3;

  // Per-entry store fields; data and id live in their own parametrised arrays.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [FN3_W-1:0]  fn3;
    logic              is_float;
  } sq_param_entry_t;

  // Pointer width: index bits plus one wrap bit.
  function automatic int unsigned sq_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_queue_param.sv
// In-order store queue: speculative stores wait for release, released stores
// drain to the cache write port, and a flush drops everything not yet released.
module store_queue_param
  import store_queue_param_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_W       = LOG2_MAX_IDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [ADDR_W-1:0]     push_addr_i,
  input  logic [BE_W-1:0]       push_be_i,
  input  logic [FN3_W-1:0]      push_fn3_i,
  input  logic                  push_is_float_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [ID_W-1:0]       push_id_i,
  input  logic                  release_i,
  input  logic                  flush_i,
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic [ADDR_W-1:0]     pop_addr_o,
  output logic [BE_W-1:0]       pop_be_o,
  output logic [FN3_W-1:0]      pop_fn3_o,
  output logic                  pop_is_float_o,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [ID_W-1:0]       pop_id_o,
  input  logic [ADDR_W-1:0]     load_addr_i,
  output logic                  load_conflict_o,
  output logic                  sq_empty_o,
  output logic                  no_released_stores_pending_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = sq_ptr_w(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] rel_q, rel_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  sq_param_entry_t       entry_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [ID_W-1:0]       id_q    [DEPTH];

  logic             full;
  logic             do_push;
  logic             do_rel;
  logic             do_pop;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic [PTR_W-1:0] count;
  logic [DEPTH-1:0] valid_mask;
  logic             unused_load_lsb;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign count    = tail_q - head_q;

  // Full when the wrap bits differ but the index bits match.
  assign full = (tail_q[IDX_W] != head_q[IDX_W]) && (tail_idx == head_idx);

  assign push_ready_o = !full && !flush_i;
  assign do_push      = push_valid_i && push_ready_o;
  assign do_rel       = release_i && (rel_q != tail_q);
  assign pop_valid_o  = (head_q != rel_q);
  assign do_pop       = pop_valid_o && pop_ready_i;

  // Release is applied before flush so a store retiring in the flush cycle survives.
  always_comb begin
    head_d = head_q + PTR_W'(do_pop);
    rel_d  = rel_q + PTR_W'(do_rel);
    tail_d = tail_q;
    if (flush_i) begin
      tail_d = rel_d;
    end else if (do_push) begin
      tail_d = tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      rel_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      rel_q  <= rel_d;
      tail_q <= tail_d;
    end
  end

  // Storage array is intentionally left unreset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      entry_q[tail_idx].addr     <= push_addr_i;
      entry_q[tail_idx].be       <= push_be_i;
      entry_q[tail_idx].fn3      <= push_fn3_i;
      entry_q[tail_idx].is_float <= push_is_float_i;
      data_q[tail_idx]           <= push_data_i;
      id_q[tail_idx]             <= push_id_i;
    end
  end

  assign pop_addr_o     = entry_q[head_idx].addr;
  assign pop_be_o       = entry_q[head_idx].be;
  assign pop_fn3_o      = entry_q[head_idx].fn3;
  assign pop_is_float_o = entry_q[head_idx].is_float;
  assign pop_data_o     = data_q[head_idx];
  assign pop_id_o       = id_q[head_idx];

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    valid_mask      = '0;
    load_conflict_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_mask[i] = PTR_W'(IDX_W'(i) - head_idx) < count;
      if (valid_mask[i] && (entry_q[i].addr[ADDR_W-1:2] == load_addr_i[ADDR_W-1:2])) begin
        load_conflict_o = 1'b1;
      end
    end
  end

  assign unused_load_lsb = ^load_addr_i[1:0];

  assign sq_empty_o                   = (head_q == tail_q);
  assign no_released_stores_pending_o = (head_q == rel_q);

endmodule

// File: tb/tb_store_queue_param.sv
// Scoreboard bench for store_queue_param: stimulus queues expected pops on release,
// a negedge monitor compares every popped entry in order.
module tb_store_queue_param;
  import store_queue_param_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = FLEN_INTERNAL;
  localparam int unsigned IDW   = LOG2_MAX_IDS;

  typedef struct {
    logic [31:0]    addr;
    logic [3:0]     be;
    logic [2:0]     fn3;
    logic           fl;
    logic [DW-1:0]  data;
    logic [IDW-1:0] id;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           push_valid, push_ready, push_is_float;
  logic [31:0]    push_addr;
  logic [3:0]     push_be;
  logic [2:0]     push_fn3;
  logic [DW-1:0]  push_data;
  logic [IDW-1:0] push_id;
  logic           rel_in, flush;
  logic           pop_valid, pop_ready, pop_is_float;
  logic [31:0]    pop_addr;
  logic [3:0]     pop_be;
  logic [2:0]     pop_fn3;
  logic [DW-1:0]  pop_data;
  logic [IDW-1:0] pop_id;
  logic [31:0]    load_addr;
  logic           load_conflict, sq_empty, nrsp;

  exp_t           exp_q[$];
  exp_t           mdl[$];
  int             n_chk  = 0;
  int             n_pass = 0;
  logic [IDW-1:0] next_id = '0;

  store_queue_param #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst),
    .push_valid_i(push_valid), .push_ready_o(push_ready),
    .push_addr_i(push_addr), .push_be_i(push_be), .push_fn3_i(push_fn3),
    .push_is_float_i(push_is_float), .push_data_i(push_data), .push_id_i(push_id),
    .release_i(rel_in), .flush_i(flush),
    .pop_valid_o(pop_valid), .pop_ready_i(pop_ready),
    .pop_addr_o(pop_addr), .pop_be_o(pop_be), .pop_fn3_o(pop_fn3),
    .pop_is_float_o(pop_is_float), .pop_data_o(pop_data), .pop_id_o(pop_id),
    .load_addr_i(load_addr), .load_conflict_o(load_conflict),
    .sq_empty_o(sq_empty), .no_released_stores_pending_o(nrsp)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endfunction

  function automatic logic [DW-1:0] dat(input logic [31:0] a);
    return DW'({2'b01, a ^ 32'h5A5A_0000});
  endfunction

  // Monitor: every handshake on the pop port must match the oldest released store.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && pop_valid && pop_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 64'(pop_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pop_addr", 64'(pop_addr), 64'(e.addr));
        chk("pop_be", 64'(pop_be), 64'(e.be));
        chk("pop_fn3", 64'(pop_fn3), 64'(e.fn3));
        chk("pop_is_float", 64'(pop_is_float), 64'(e.fl));
        chk("pop_data", 64'(pop_data), 64'(e.data));
        chk("pop_id", 64'(pop_id), 64'(e.id));
      end
    end
  end

  task automatic idle();
    push_valid = 1'b0; push_addr = '0; push_be = '0; push_fn3 = '0;
    push_is_float = 1'b0; push_data = '0; push_id = '0;
    rel_in = 1'b0; flush = 1'b0; pop_ready = 1'b0;
  endtask

  // One cycle of stimulus; updates the bench model with the expected outcome.
  task automatic drive(input logic pv, input logic [31:0] a, input logic [DW-1:0] d,
                       input logic fl, input logic rel, input logic fls, input logic pr);
    exp_t e;
    int   occ;
    logic exp_rdy;
    push_valid = pv; push_addr = a; push_data = d; push_is_float = fl;
    push_be = a[5:2]; push_fn3 = fl ? 3'b010 : a[4:2]; push_id = next_id;
    rel_in = rel; flush = fls; pop_ready = pr;
    #1;
    occ     = exp_q.size() + mdl.size();
    exp_rdy = !fls && (occ < int'(DEPTH));
    if (pv) chk("push_ready", 64'(push_ready), 64'(exp_rdy));
    if (rel) begin
      if (mdl.size() == 0) chk("release_guard", 64'd0, 64'd1);
      else exp_q.push_back(mdl.pop_front());
    end
    if (fls) begin
      mdl.delete();
    end else if (pv && exp_rdy) begin
      e.addr = a; e.be = a[5:2]; e.fn3 = fl ? 3'b010 : a[4:2];
      e.fl = fl; e.data = d; e.id = next_id;
      mdl.push_back(e);
      next_id++;
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [31:0] a);
    drive(1'b1, a, dat(a), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    pop_ready = 1'b1;
    for (int k = 0; k < 4 * int'(DEPTH) && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    pop_ready = 1'b0;
    chk("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    load_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("rst_sq_empty", 64'(sq_empty), 64'd1);
    chk("rst_nrsp", 64'(nrsp), 64'd1);
    chk("rst_conflict", 64'(load_conflict), 64'd0);

    // Fill without release.
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i));
    #1;
    chk("full_push_ready", 64'(push_ready), 64'd0);
    chk("full_pop_valid", 64'(pop_valid), 64'd0);
    chk("full_sq_empty", 64'(sq_empty), 64'd0);
    chk("full_nrsp", 64'(nrsp), 64'd1);
    push(32'h110);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("flush_empty", 64'(sq_empty), 64'd1);

    // Minimum push-to-pop latency.
    push(32'h200);
    #1;
    chk("p2p_empty", 64'(sq_empty), 64'd0);
    chk("p2p_pv0", 64'(pop_valid), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("p2p_pv1", 64'(pop_valid), 64'd1);
    chk("p2p_addr", 64'(pop_addr), 64'h200);
    chk("p2p_nrsp", 64'(nrsp), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("p2p_after_empty", 64'(sq_empty), 64'd1);
    chk("p2p_after_nrsp", 64'(nrsp), 64'd1);

    // Release and flush together; push in a flush cycle is refused.
    push(32'h400); push(32'h404); push(32'h408);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h40C, dat(32'h40C), 1'b0, 1'b1, 1'b1, 1'b0);
    #1 chk("rf_pop_valid", 64'(pop_valid), 64'd1);
    drain();
    chk("rf_empty", 64'(sq_empty), 64'd1);

    // Word-granular load conflict.
    push(32'h300);
    load_addr = 32'h302; #1 chk("conf_302", 64'(load_conflict), 64'd1);
    load_addr = 32'h303; #1 chk("conf_303", 64'(load_conflict), 64'd1);
    load_addr = 32'h304; #1 chk("conf_304", 64'(load_conflict), 64'd0);
    load_addr = 32'h2FC; #1 chk("conf_2FC", 64'(load_conflict), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    load_addr = 32'h300; #1 chk("conf_flushed", 64'(load_conflict), 64'd0);
    load_addr = '0;

    // Pop at full: no same-cycle bypass, push lands next cycle.
    for (int i = 0; i < 4; i++) push(32'h600 + 32'(4 * i));
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h610, dat(32'h610), 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h610, dat(32'h610), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    // Streaming push/release/pop so every pointer wraps several times.
    for (int i = 0; i < 3 * int'(DEPTH); i++)
      drive(1'b1, 32'h700 + 32'(4 * i), dat(32'h700 + 32'(4 * i)), 1'b0,
            mdl.size() > 0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    chk("wrap_empty", 64'(sq_empty), 64'd1);

    // Internal float format store.
    drive(1'b1, 32'h500, 34'h2_DEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("fp_data", 64'(pop_data), 64'h2_DEAD_BEEF);
    chk("fp_is_float", 64'(pop_is_float), 64'd1);
    drain();

    // Asynchronous reset mid-cycle loses even released stores.
    push(32'h800); push(32'h804);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_empty", 64'(sq_empty), 64'd1);
    chk("arst_pop_valid", 64'(pop_valid), 64'd0);
    chk("arst_nrsp", 64'(nrsp), 64'd1);
    chk("arst_push_ready", 64'(push_ready), 64'd1);
    exp_q.delete();
    mdl.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    push(32'h900);
    #1 chk("post_rst_empty", 64'(sq_empty), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
